// File: rtl/uart_tx.sv
// uart_tx: UART transmitter. It accepts one DATA_BITS-wide word over a valid/ready
// handshake and shifts it out LSB-first as a frame: start bit, data bits,
// optional even-parity bit, then stop bit.
// Optional feature macro: UART_TX_PARITY_EN. When it is defined, an even-parity
// bit is sent after the data bits.
// tx is registered and is set to its idle level by the asynchronous reset.
// tx_ready and tx_busy are decoded directly from the state register.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 async_reset_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;
`endif

  state_e                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  baud_last;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  // Ready and busy are plain decodes of the current state
  assign tx_ready = (state_q == ST_IDLE);
  assign tx_busy  = (state_q != ST_IDLE);
  assign tx       = tx_q;

  // Next-state logic. tx_d is the line level of the next state, so the line
  // changes on the same edge as the state transition.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    tx_d      = 1'b1;
    baud_last = (baud_q == BAUD_LAST);

    case (state_q)
      ST_IDLE: begin
        if (tx_valid && tx_ready) begin
          shift_d  = tx_data;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_data;
`endif
          baud_d   = '0;
          bit_d    = '0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = bit_q + BIT_W'(1);
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = ST_STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`endif
      ST_STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = ST_IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        baud_d  = '0;
        bit_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    // Line level presented while in the next state
    case (state_d)
      ST_IDLE:   tx_d = 1'b1;
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_q;
`endif
      ST_STOP:   tx_d = 1'b1;
      default:   tx_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset forces the line idle immediately
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx (CLKS_PER_BIT=4, DATA_BITS=8).
// The reference model is a queue of expected line levels: each accepted word
// pushes its whole frame, one entry per clock. Respect UART_TX_PARITY_EN.
module tb_uart_tx;

  localparam int CPB = 4;
  localparam int DB  = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
  localparam int FRAME_CYC  = 44;
`else
  localparam int FRAME_BITS = 10;
  localparam int FRAME_CYC  = 40;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [DB-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready, tx, tx_busy;

  bit clk_en = 1'b0;
  bit chk_en = 1'b0;
  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  logic exp_q[$];
  int   hs_cyc[$];
  logic m_ready = 1'b1;
  logic e_tx, e_busy;

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk          (clk),
    .async_reset_n(rst_n),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx           (tx),
    .tx_busy      (tx_busy)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_v(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected frame built from the framing rules: start, data LSB-first, parity, stop
  function automatic void push_frame(input logic [DB-1:0] d);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back(^d);
`endif
    bits.push_back(1'b1);
    foreach (bits[b])
      for (int k = 0; k < CPB; k++) exp_q.push_back(bits[b]);
  endfunction

  // Model acceptance: a word is taken on an edge where the model was idle
  always @(posedge clk) begin
    cyc++;
    if (chk_en && rst_n && tx_valid && m_ready) begin
      push_frame(tx_data);
      hs_cyc.push_back(cyc);
    end
  end

  // Per-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    if (chk_en) begin
      if (!rst_n) begin
        exp_q.delete();
        e_tx = 1'b1; e_busy = 1'b0;
      end else if (exp_q.size() > 0) begin
        e_tx = exp_q.pop_front(); e_busy = 1'b1;
      end else begin
        e_tx = 1'b1; e_busy = 1'b0;
      end
      m_ready = !e_busy;
      chk("tx", tx, e_tx);
      chk("tx_busy", tx_busy, e_busy);
      chk("tx_ready", tx_ready, !e_busy);
    end
  end

  // Offer a word and return at the negedge after it has been accepted
  task automatic send(input logic [DB-1:0] d, input bit hold);
    int n;
    n = 0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    while (!tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      vectors++;
      errors++;
      $display("FAIL send_timeout: tx_ready never rose for 0x%0h", d);
    end
    @(negedge clk);
    if (!hold) tx_valid = 1'b0;
    tx_data = DB'($urandom);
  endtask

  // Sample the middle of each bit of the current frame and count busy cycles
  task automatic capture(output logic [15:0] bits, output int busy_cnt);
    bits = '0;
    busy_cnt = 0;
    for (int c = 0; c < CPB * FRAME_BITS + 4; c++) begin
      if ((c % CPB) == 1 && (c / CPB) < FRAME_BITS) bits[c / CPB] = tx;
      if (tx_busy) busy_cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] bits;
    int          bc;

    // Reset with the clock stopped
    #2 rst_n = 1'b0;
    #2;
    chk("reset_tx", tx, 1'b1);
    chk("reset_ready", tx_ready, 1'b1);
    chk("reset_busy", tx_busy, 1'b0);

    clk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single frame 0xA5
    send(8'hA5, 1'b0);
    capture(bits, bc);
`ifdef UART_TX_PARITY_EN
    chk_v("frame_a5", int'(bits), 32'h54A);
    chk_v("busy_len_a5", bc, 44);
`else
    chk_v("frame_a5", int'(bits), 32'h34A);
    chk_v("busy_len_a5", bc, 40);
`endif
    chk("ready_after_a5", tx_ready, 1'b1);

    // 0x07 has odd weight, so its parity bit is 1
    send(8'h07, 1'b0);
    capture(bits, bc);
`ifdef UART_TX_PARITY_EN
    chk_v("frame_07", int'(bits), 32'h60E);
`else
    chk_v("frame_07", int'(bits), 32'h20E);
`endif

    // Back-to-back frames, with tx_valid held and tx_data scrambled mid-frame
    send(8'h55, 1'b1);
    send(8'hFF, 1'b0);
    chk_v("b2b_spacing", hs_cyc[hs_cyc.size()-1] - hs_cyc[hs_cyc.size()-2], FRAME_CYC + 1);
    capture(bits, bc);
`ifdef UART_TX_PARITY_EN
    chk_v("frame_ff", int'(bits), 32'h5FE);
`else
    chk_v("frame_ff", int'(bits), 32'h3FE);
`endif

    // tx_valid pulsed during DATA is ignored
    send(8'h3C, 1'b0);
    repeat (14) @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (FRAME_CYC) @(negedge clk);
    chk("no_second_frame", tx_busy, 1'b0);

    // Reset asserted during data bit 3 of 0xF0 (bit 3 is 0)
    send(8'hF0, 1'b0);
    repeat (17) @(negedge clk);
    chk("bit3_low", tx, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_tx", tx, 1'b1);
    chk("abort_busy", tx_busy, 1'b0);
    chk("abort_ready", tx_ready, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send(8'h81, 1'b0);
    capture(bits, bc);
`ifdef UART_TX_PARITY_EN
    chk_v("frame_81", int'(bits), 32'h502);
`else
    chk_v("frame_81", int'(bits), 32'h302);
`endif

    // Random valid/data traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      tx_valid = (($urandom % 6) == 0);
      tx_data  = DB'($urandom);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (FRAME_CYC + 8) @(negedge clk);
    chk("final_idle", tx_busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
